axis_cfg_sched: RTL

AXIS_CFG_SCHED -- requirements
Module: axis_cfg_sched

---
 rtl/axis_cfg_sched_pkg.sv | 16 +
 rtl/cfg_fifo.sv | 51 +++++
 rtl/axis_cfg_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axis_cfg_sched_pkg.sv
// Shared definitions for the axis engine config scheduler: FSM encoding and
// default engine register addresses.
package axis_cfg_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST,
    ST_ID,
    ST_ADDR,
    ST_LEN
  } state_e;

  localparam int unsigned DEF_CONFIG_ADDR = 0;
  localparam int unsigned DEF_CONFIG_DATA = 1;

endpackage

// File: rtl/cfg_fifo.sv
// First-word-fall-through FIFO holding pending host config writes. A push
// while full is accepted only when a pop frees a slot in the same cycle.
module cfg_fifo #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH:0]   wr_ptr_q;
  logic [AWIDTH:0]   rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                   (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_q[AWIDTH-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AWIDTH+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AWIDTH+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AWIDTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/axis_cfg_sched.sv
// Serialises host config writes and three-beat descriptor sequences onto a
// single registered axis engine config bus; host writes take priority.
module axis_cfg_sched
  import axis_cfg_sched_pkg::*;
#(
  parameter int          CFG_AWIDTH  = 5,
  parameter int          CFG_DWIDTH  = 32,
  parameter int unsigned CONFIG_ADDR = DEF_CONFIG_ADDR,
  parameter int unsigned CONFIG_DATA = DEF_CONFIG_DATA,
  parameter int          HQ_AWIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CFG_AWIDTH-1:0] host_addr,
  input  logic [CFG_DWIDTH-1:0] host_data,
  input  logic                  host_valid,
  input  logic [CFG_DWIDTH-1:0] desc_id,
  input  logic [CFG_DWIDTH-1:0] desc_addr,
  input  logic [CFG_DWIDTH-1:0] desc_len,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic                  host_ovf,
  output logic [CFG_DWIDTH-1:0] seq_cnt
);

  localparam int EW = CFG_AWIDTH + CFG_DWIDTH;

  state_e                state_q, state_d;
  logic [EW-1:0]         fifo_rdata;
  logic [CFG_AWIDTH-1:0] head_addr;
  logic [CFG_DWIDTH-1:0] head_data;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  accept;
  logic                  seq_inc;
  logic                  run_q;
  logic [CFG_DWIDTH-1:0] desc_addr_q;
  logic [CFG_DWIDTH-1:0] desc_len_q;
  logic                  beat_valid;
  logic [CFG_AWIDTH-1:0] beat_addr;
  logic [CFG_DWIDTH-1:0] beat_data;

  cfg_fifo #(
    .WIDTH  (EW),
    .AWIDTH (HQ_AWIDTH)
  ) u_host_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host_valid),
    .wdata ({host_addr, host_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign {head_addr, head_data} = fifo_rdata;

  // run_q keeps desc_ready low while reset is asserted.
  assign desc_ready = run_q && (state_q == ST_IDLE) && fifo_empty && !host_valid;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_valid = 1'b0;
    beat_addr  = '0;
    beat_data  = '0;
    pop        = 1'b0;
    accept     = 1'b0;
    seq_inc    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_d    = ST_HOST;
          beat_valid = 1'b1;
          beat_addr  = head_addr;
          beat_data  = head_data;
        end else if (desc_valid && desc_ready) begin
          accept     = 1'b1;
          state_d    = ST_ID;
          beat_valid = 1'b1;
          beat_addr  = CFG_AWIDTH'(CONFIG_ADDR);
          beat_data  = desc_id;
        end
      end
      ST_HOST: state_d = ST_IDLE;
      ST_ID: begin
        state_d    = ST_ADDR;
        beat_valid = 1'b1;
        beat_addr  = CFG_AWIDTH'(CONFIG_DATA);
        beat_data  = desc_addr_q;
      end
      ST_ADDR: begin
        state_d    = ST_LEN;
        beat_valid = 1'b1;
        beat_addr  = CFG_AWIDTH'(CONFIG_DATA);
        beat_data  = desc_len_q;
      end
      ST_LEN: begin
        state_d = ST_IDLE;
        seq_inc = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The beat for each state is computed one cycle ahead so the bus is
  // registered while the state register shows the beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_valid   <= 1'b0;
      cfg_addr    <= '0;
      cfg_data    <= '0;
      seq_cnt     <= '0;
      host_ovf    <= 1'b0;
      run_q       <= 1'b0;
      desc_addr_q <= '0;
      desc_len_q  <= '0;
    end else begin
      state_q   <= state_d;
      cfg_valid <= beat_valid;
      cfg_addr  <= beat_addr;
      cfg_data  <= beat_data;
      run_q     <= 1'b1;
      if (seq_inc) seq_cnt <= seq_cnt + CFG_DWIDTH'(1);
      if (host_valid && fifo_full && !pop) host_ovf <= 1'b1;
      if (accept) begin
        desc_addr_q <= desc_addr;
        desc_len_q  <= desc_len;
      end
    end
  end

endmodule
